// File: rtl/mpu6050_i2c_target_if.sv
// Board-side I2C pins plus the register-write observation port of the
// MPU-6050 target emulator.
interface mpu6050_i2c_target_if;
  logic       I_SCL;
  logic       I_SDA;
  logic       O_SDA_OE;
  logic       O_BUSY;
  logic       O_WR_STB;
  logic [6:0] O_WR_ADDR;
  logic [7:0] O_WR_DATA;

  modport master (
    output I_SCL, I_SDA,
    input  O_SDA_OE, O_BUSY, O_WR_STB, O_WR_ADDR, O_WR_DATA
  );

  modport slave (
    input  I_SCL, I_SDA,
    output O_SDA_OE, O_BUSY, O_WR_STB, O_WR_ADDR, O_WR_DATA
  );
endinterface

// File: rtl/mpu6050_i2c_target.sv
// I2C target emulating the MPU-6050 register map for the master/ROM
// loopback build. 128x8 register file with an auto-incrementing 7-bit
// pointer, read-only WHO_AM_I at 0x75.
// Optional macro MPU_SAMPLE_GEN_EN: periodically loads synthetic
// accel/temp/gyro data into 0x3B-0x48 and a FIFO count into 0x72/0x73.
module mpu6050_i2c_target #(
  parameter logic [6:0] DEV_ADDR      = 7'h68,
  parameter logic [7:0] WHO_AM_I      = 8'h68,
  parameter int         SAMPLE_PERIOD = 50000
) (
  input logic                 CLK,
  input logic                 RST_n,
  mpu6050_i2c_target_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  localparam logic [6:0] WHO_IDX = 7'h75;

  // ---------------------------------------------------------------------
  // Synchronizers and bus event detection
  // ---------------------------------------------------------------------
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic       scl, sda;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // 2-FF synchronizers plus one history stage; reset to the idle (high) bus
  // level so that leaving reset never fakes an edge.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.I_SCL};
      sda_sync <= {sda_sync[0], bus.I_SDA};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl       = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;

  // ---------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------
  state_t     state, state_nx;
  logic [3:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic [6:0] ptr, ptr_nx;
  logic       rw, rw_nx;
  logic       sda_oe, sda_oe_nx;
  logic       busy, busy_nx;
  logic       wr_stb, wr_stb_nx;
  logic [6:0] wr_addr, wr_addr_nx;
  logic [7:0] wr_data, wr_data_nx;
  logic       reg_we;

  logic [7:0] regs [128];
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;

  // Byte completed by the bit being sampled on this SCL rise.
  assign rx_byte = {shreg[6:0], sda};
  assign rd_byte = (ptr == WHO_IDX) ? WHO_AM_I : regs[ptr];

  // State register; SDA drive and outputs drop asynchronously on reset.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      ptr     <= ptr_nx;
      rw      <= rw_nx;
      sda_oe  <= sda_oe_nx;
      busy    <= busy_nx;
      wr_stb  <= wr_stb_nx;
      wr_addr <= wr_addr_nx;
      wr_data <= wr_data_nx;
    end
  end

  // Next-state logic. SDA drive only changes on a detected SCL fall. In the
  // *_ACK states the first fall asserts the ACK and the second fall ends it,
  // so sda_oe itself marks which half of the ACK slot we are in.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    ptr_nx     = ptr;
    rw_nx      = rw;
    sda_oe_nx  = sda_oe;
    busy_nx    = busy;
    wr_stb_nx  = 1'b0;
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;
    reg_we     = 1'b0;

    if (stop_det) begin
      state_nx  = IDLE;
      sda_oe_nx = 1'b0;
      busy_nx   = 1'b0;
    end else if (start_det) begin
      state_nx   = ADDR;
      bit_cnt_nx = '0;
      sda_oe_nx  = 1'b0;
      busy_nx    = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shreg_nx   = rx_byte;
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_nx = ADDR_ACK;
                rw_nx    = rx_byte[0];
                busy_nx  = 1'b1;
              end else begin
                state_nx = IDLE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nx = 1'b1;
            end else if (rw) begin
              // Read: latch the first byte and present its MSB right away.
              shreg_nx   = rd_byte;
              sda_oe_nx  = ~rd_byte[7];
              bit_cnt_nx = '0;
              state_nx   = RDATA;
            end else begin
              sda_oe_nx  = 1'b0;
              bit_cnt_nx = '0;
              state_nx   = PTR;
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            shreg_nx   = rx_byte;
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ptr_nx   = rx_byte[6:0];
              state_nx = PTR_ACK;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nx = 1'b1;
            end else begin
              sda_oe_nx  = 1'b0;
              bit_cnt_nx = '0;
              state_nx   = WDATA;
            end
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shreg_nx   = rx_byte;
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              // WHO_AM_I is read-only: still ACKed, silently dropped.
              if (ptr != WHO_IDX) begin
                reg_we     = 1'b1;
                wr_stb_nx  = 1'b1;
                wr_addr_nx = ptr;
                wr_data_nx = rx_byte;
              end
              ptr_nx   = ptr + 7'd1;
              state_nx = WDATA_ACK;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nx  = 1'b0;
              bit_cnt_nx = '0;
              state_nx   = RDATA_ACK;
            end else begin
              sda_oe_nx = ~shreg[6];
              shreg_nx  = {shreg[6:0], 1'b0};
            end
          end
        end
        RDATA_ACK: begin
          // bit_cnt == 1 records that the master ACKed on this slot.
          if (scl_rise) begin
            if (sda) begin
              state_nx = IDLE;
            end else begin
              ptr_nx     = ptr + 7'd1;
              bit_cnt_nx = 4'd1;
            end
          end else if (scl_fall && bit_cnt == 4'd1) begin
            shreg_nx   = rd_byte;
            sda_oe_nx  = ~rd_byte[7];
            bit_cnt_nx = '0;
            state_nx   = RDATA;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Optional synthetic sample generator
  // ---------------------------------------------------------------------
`ifdef MPU_SAMPLE_GEN_EN
  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  logic [CNT_W-1:0] samp_cnt;
  logic             samp_pend;
  logic [15:0]      samp_n;
  logic             samp_load;

  // Held off while addressed so a burst read never straddles an update.
  assign samp_load = samp_pend & ~busy;

  // Period counter; a reload raises a pending update that lands when idle.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      samp_cnt  <= '0;
      samp_pend <= 1'b0;
      samp_n    <= '0;
    end else begin
      if (samp_load) begin
        samp_pend <= 1'b0;
        samp_n    <= samp_n + 16'd1;
      end
      if (samp_cnt == CNT_W'(SAMPLE_PERIOD - 1)) begin
        samp_cnt  <= '0;
        samp_pend <= 1'b1;
      end else begin
        samp_cnt <= samp_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_sample_period;
  assign unused_sample_period = ^SAMPLE_PERIOD;
`endif

  // Register file: bus writes, plus synthetic sample loads when enabled.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < 128; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[ptr] <= rx_byte;
    end
`ifdef MPU_SAMPLE_GEN_EN
    else if (samp_load) begin
      for (int k = 0; k < 7; k++) begin
        regs[7'(59 + 2 * k)] <= 8'((samp_n + 16'(k)) >> 8);
        regs[7'(60 + 2 * k)] <= 8'(samp_n + 16'(k));
      end
      regs[7'h72] <= 8'd0;
      regs[7'h73] <= 8'd14;
    end
`endif
  end

  assign bus.O_SDA_OE  = sda_oe;
  assign bus.O_BUSY    = busy;
  assign bus.O_WR_STB  = wr_stb;
  assign bus.O_WR_ADDR = wr_addr;
  assign bus.O_WR_DATA = wr_data;

endmodule

// File: tb/tb_mpu6050_i2c_target.sv
// Scoreboard bench for mpu6050_i2c_target: a bit-banged I2C master drives
// directed transactions, expectations are queued at issue time and two
// monitor processes compare bus-observed bytes/ACKs and write strobes.
module tb_mpu6050_i2c_target;

  localparam int Q = 8;  // quarter of an SCL period, in CLK cycles

  typedef struct {
    string      name;
    logic [7:0] val;
  } item_t;

  logic CLK;
  logic RST_n;
  logic scl, m_sda;

  mpu6050_i2c_target_if bus();

  assign bus.I_SCL = scl;
  assign bus.I_SDA = m_sda & ~bus.O_SDA_OE;  // open-drain wired-AND

  mpu6050_i2c_target #(.SAMPLE_PERIOD(100)) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  item_t       exp_q[$];
  logic [7:0]  obs_q[$];
  logic [14:0] exp_wr_q[$];
  logic        saw_oe, saw_busy;

  function automatic void check(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", n, act, exp);
  endfunction

  // Byte/ACK scoreboard: pop one expectation per observed bus item.
  initial begin
    item_t      e;
    logic [7:0] o;
    forever begin
      @(negedge CLK);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL sb_unexpected: got %02h, expected nothing", o);
        end else begin
          e = exp_q.pop_front();
          check(e.name, {24'd0, o}, {24'd0, e.val});
        end
      end
    end
  end

  // Write-strobe monitor: each high cycle of O_WR_STB is one write.
  initial begin
    logic [14:0] w;
    forever begin
      @(negedge CLK);
      if (bus.O_SDA_OE) saw_oe = 1'b1;
      if (bus.O_BUSY) saw_busy = 1'b1;
      if (bus.O_WR_STB === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          total++;
          $display("FAIL wr_stray: got addr %02h data %02h, expected no strobe",
                   bus.O_WR_ADDR, bus.O_WR_DATA);
        end else begin
          w = exp_wr_q.pop_front();
          check("wr_addr", {25'd0, bus.O_WR_ADDR}, {25'd0, w[14:8]});
          check("wr_data", {24'd0, bus.O_WR_DATA}, {24'd0, w[7:0]});
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_b(string n, logic [7:0] v);
    exp_q.push_back('{name: n, val: v});
  endtask

  task automatic start_c();
    m_sda = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic stop_c();
    m_sda = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic bit_w(logic b);
    m_sda = b;    tick(Q);
    scl   = 1'b1; tick(2 * Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic bit_r(output logic b);
    m_sda = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    b     = bus.I_SDA; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic wbyte(logic [7:0] b);
    logic a;
    for (int i = 7; i >= 0; i--) bit_w(b[i]);
    bit_r(a);
    obs_q.push_back({7'd0, a});
  endtask

  task automatic rbyte(logic nack, logic chk, output logic [7:0] v);
    for (int i = 7; i >= 0; i--) bit_r(v[i]);
    if (chk) obs_q.push_back(v);
    bit_w(nack);
  endtask

  // Pointer write, repeated START, read cnt bytes (expected bytes MSB-first).
  task automatic read_seq(string n, logic [7:0] p, int cnt, logic [23:0] exp);
    logic [7:0] v;
    expect_b({n, "_ack_aw"}, 8'h00);
    expect_b({n, "_ack_ptr"}, 8'h00);
    expect_b({n, "_ack_ar"}, 8'h00);
    for (int i = 0; i < cnt; i++) expect_b({n, "_data"}, exp[8 * (cnt - 1 - i) +: 8]);
    start_c(); wbyte(8'hD0); wbyte(p);
    start_c(); wbyte(8'hD1);
    for (int i = 0; i < cnt; i++) rbyte(i == cnt - 1, 1'b1, v);
    stop_c();
  endtask

  // Pointer + data write; strobes expected for every register except 0x75.
  task automatic write_seq(string n, logic [7:0] p, int cnt, logic [23:0] d);
    logic [6:0] a;
    logic [7:0] b;
    expect_b({n, "_ack_aw"}, 8'h00);
    expect_b({n, "_ack_ptr"}, 8'h00);
    for (int i = 0; i < cnt; i++) begin
      expect_b({n, "_ack_wd"}, 8'h00);
      a = 7'(p[6:0] + 7'(i));
      b = d[8 * (cnt - 1 - i) +: 8];
      if (a != 7'h75) exp_wr_q.push_back({a, b});
    end
    start_c(); wbyte(8'hD0); wbyte(p);
    for (int i = 0; i < cnt; i++) wbyte(d[8 * (cnt - 1 - i) +: 8]);
    stop_c();
  endtask

  initial begin
    logic       b;
    logic [7:0] v;
    scl = 1'b1; m_sda = 1'b1; RST_n = 1'b0;
    saw_oe = 1'b0; saw_busy = 1'b0;
    tick(5);
    check("rst_sda_oe",  {31'd0, bus.O_SDA_OE}, 32'd0);
    check("rst_busy",    {31'd0, bus.O_BUSY},   32'd0);
    check("rst_wr_stb",  {31'd0, bus.O_WR_STB}, 32'd0);
    check("rst_wr_addr", {25'd0, bus.O_WR_ADDR}, 32'd0);
    check("rst_wr_data", {24'd0, bus.O_WR_DATA}, 32'd0);
    RST_n = 1'b1;
    tick(5);

    // Chip-id check with busy observed mid-transaction.
    expect_b("cid_ack_aw", 8'h00); expect_b("cid_ack_ptr", 8'h00);
    expect_b("cid_ack_ar", 8'h00); expect_b("cid_data", 8'h68);
    start_c(); wbyte(8'hD0); wbyte(8'h75);
    start_c(); wbyte(8'hD1);
    check("cid_busy_on", {31'd0, bus.O_BUSY}, 32'd1);
    rbyte(1'b1, 1'b1, v);
    stop_c(); tick(4);
    check("cid_sda_rel", {31'd0, bus.O_SDA_OE}, 32'd0);
    check("cid_busy_off", {31'd0, bus.O_BUSY}, 32'd0);

    // FIFO enable write and readback.
    write_seq("fifo_wr", 8'h23, 1, 24'h0000F8);
    read_seq("fifo_rd", 8'h23, 1, 24'h0000F8);

    // Burst write across the 0x7F -> 0x00 wrap, then auto-increment read.
    write_seq("wrap_wr", 8'h7E, 3, 24'h112233);
    read_seq("wrap_rd", 8'h7E, 3, 24'h112233);

    // Pointer persists: a plain read starts where the last read left off
    // (0x7E burst ended on 0x00 after two ACKs).
    expect_b("persist_ack", 8'h00); expect_b("persist_data", 8'h33);
    start_c(); wbyte(8'hD1); rbyte(1'b1, 1'b1, v); stop_c();

    // Wrong address: no ACK, no drive, no busy.
    tick(4);
    saw_oe = 1'b0; saw_busy = 1'b0;
    expect_b("bad_addr_nack", 8'h01);
    start_c(); wbyte(8'hA0); stop_c(); tick(4);
    check("bad_addr_no_oe", {31'd0, saw_oe}, 32'd0);
    check("bad_addr_no_busy", {31'd0, saw_busy}, 32'd0);

    // Read-only WHO_AM_I.
    write_seq("ro_wr", 8'h75, 1, 24'h000055);
    read_seq("ro_rd", 8'h75, 1, 24'h000068);

    // Reset in the middle of a chip-id read while SDA is held low (bit 4).
    expect_b("rst_ack_aw", 8'h00); expect_b("rst_ack_ptr", 8'h00);
    expect_b("rst_ack_ar", 8'h00);
    start_c(); wbyte(8'hD0); wbyte(8'h75);
    start_c(); wbyte(8'hD1);
    for (int i = 0; i < 3; i++) bit_r(b);
    check("rst_pre_oe", {31'd0, bus.O_SDA_OE}, 32'd1);
    RST_n = 1'b0;
    #1;
    check("rst_async_oe", {31'd0, bus.O_SDA_OE}, 32'd0);
    tick(2);
    scl = 1'b1; m_sda = 1'b1;
    tick(4);
    RST_n = 1'b1;
    tick(4);
    read_seq("post_rst_reg", 8'h23, 1, 24'h000000);
    read_seq("post_rst_cid", 8'h75, 1, 24'h000068);

`ifdef MPU_SAMPLE_GEN_EN
    begin
      logic [7:0]  sb [14];
      logic [15:0] pr [7];
      tick(300);
      expect_b("samp_ack_aw", 8'h00); expect_b("samp_ack_ptr", 8'h00);
      expect_b("samp_ack_ar", 8'h00);
      start_c(); wbyte(8'hD0); wbyte(8'h3B);
      start_c(); wbyte(8'hD1);
      for (int i = 0; i < 14; i++) rbyte(i == 13, 1'b0, sb[i]);
      stop_c();
      for (int k = 0; k < 7; k++) pr[k] = {sb[2 * k], sb[2 * k + 1]};
      for (int k = 0; k < 6; k++)
        check("samp_pair_seq", {16'd0, pr[k + 1]}, {16'd0, 16'(pr[k] + 16'd1)});
    end
`endif

    // Let the monitors drain, bounded.
    for (int i = 0; i < 100 && obs_q.size() > 0; i++) tick(1);
    tick(4);
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL sb_drain: got %0d unconsumed expectations, expected 0", exp_q.size());
    end
    if (exp_wr_q.size() != 0) begin
      total++;
      $display("FAIL wr_missing: got %0d strobes short, expected 0", exp_wr_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
